i2c_master_scheduler: RTL and testbench
=======================================

I2C_MASTER_SCHEDULER -- requirements
Module: i2c_master_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one I2C master (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, clk cycles allowed per master transaction before abort.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  in  NUM_REQ  per-requester transaction request, level, held until done pulse.
REQ-006 SHALL have port req_addr  in  7*NUM_REQ  per-requester 7-bit slave address, slice i = bits [7i+6:7i].
REQ-007 SHALL have port req_rw  in  NUM_REQ  per-requester direction, 0 write, 1 read.
REQ-008 SHALL have port req_wdata  in  8*NUM_REQ  per-requester write byte.
REQ-009 SHALL have port grant  out  NUM_REQ  one-hot owner of master, 0 when idle.
REQ-010 SHALL have port done  out  NUM_REQ  one-cycle completion pulse to owner.
REQ-011 SHALL have port status  out  2  result with done: 00 ok, 01 nack, 10 timeout.
REQ-012 SHALL have port rdata  out  8  read byte, valid with done when rw=1 and status=00.
REQ-013 SHALL have port m_enable  out  1  start strobe to master, one cycle.
REQ-014 SHALL have port m_address  out  7, m_rw  out  1, m_data_in  out  8  latched command to master.
REQ-015 SHALL have port m_busy  in  1, m_done  in  1, m_nack  in  1, m_rdata  in  8  master status; m_nack/m_rdata valid with m_done pulse.

Function
REQ-016 SHALL implement FSM IDLE, ARB, ISSUE, WAIT, RESP.
REQ-017 IDLE: SHALL go to ARB when any req bit set and m_busy=0.
REQ-018 ARB: SHALL pick one requester round-robin, search starting at last_owner+1 mod NUM_REQ; SHALL latch its addr/rw/wdata into m_* and assert grant; -> ISSUE.
REQ-019 ISSUE: SHALL assert m_enable exactly one cycle, clear timeout counter; -> WAIT.
REQ-020 WAIT: SHALL increment timeout counter each cycle; on m_done -> RESP with status 01 if m_nack else 00, rdata <= m_rdata; on counter == TIMEOUT_CYC-1 without m_done -> RESP, status 10.
REQ-021 m_done and timeout in the same cycle SHALL resolve to m_done result.
REQ-022 RESP: SHALL pulse done[owner] one cycle, update last_owner, drop grant next cycle; -> IDLE.
REQ-023 Requester dropping req while granted SHALL NOT abort the transaction; done still pulses.
REQ-024 Requester still asserting req after its done SHALL be treated as a new request, lowest priority next round.
REQ-025 m_address/m_rw/m_data_in SHALL stay stable from ARB until exit from RESP.
REQ-026 Minimum latency req rise to m_enable: 3 cycles (IDLE->ARB->ISSUE) when master idle.
REQ-027 Two full back-to-back transactions SHALL have at least one IDLE cycle between done and next m_enable.
REQ-028 rdata and status SHALL hold their last value until next RESP.

Reset
REQ-029 On rst low, SHALL asynchronously force: state IDLE, grant 0, done 0, m_enable 0, status 00, rdata 0x00, m_address 0, m_rw 0, m_data_in 0, timeout counter 0, last_owner NUM_REQ-1 (requester 0 wins first).
REQ-030 Reset mid-transaction SHALL abandon it with no done pulse; first post-reset arbitration starts at requester 0.
REQ-031 Reset release SHALL be usable synchronously; no output changes in the release cycle.

Structure
REQ-032 State encodings and status codes (ST_OK, ST_NACK, ST_TIMEOUT) SHALL live in shared package i2c_pkg, reused by master and bench.
REQ-033 Round-robin selection SHALL be sub-module rr_arbiter (inputs req, last_owner; outputs one-hot grant, index), combinational.
REQ-034 Timeout counter width SHALL be clog2(TIMEOUT_CYC).

Verification
REQ-035 Single write: req[1]=1, addr 0x50, rw 0, wdata 0xA5, m_done after 40 cycles, m_nack 0 -> m_enable 3 cycles after req, m_address 0x50, done[1] pulse, status 00.
REQ-036 Read: req[2], rw 1, m_rdata 0x3C with m_done -> done[2], status 00, rdata 0x3C.
REQ-037 Contention: req=4'b1111 held after reset -> grants in order 0,1,2,3,0; never two grant bits set.
REQ-038 NACK: m_nack=1 with m_done -> status 01, done pulse, grant drops, next requester served.
REQ-039 Timeout: TIMEOUT_CYC=16, m_done never asserted -> status 10, done at cycle 16 after m_enable; m_done coinciding with cycle 16 -> status 00.
REQ-040 Reset mid-WAIT: rst low -> all outputs to reset values asynchronously, no done pulse; after release req=4'b1000 and 4'b0001 -> requester 0 served first.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master scheduler: FSM state encoding and
// transaction result codes, used by the scheduler RTL and its bench.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NACK    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_owner+1 (mod N)
// and returns the first active requester as one-hot grant plus index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_owner_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] index_o
);

    always_comb begin
        int cand;
        grant_o = '0;
        index_o = '0;
        cand    = 0;
        // Walk offsets from farthest to nearest so the nearest hit overwrites.
        for (int off = N; off >= 1; off--) begin
            cand = int'(last_owner_i) + off;
            if (cand >= N) cand = cand - N;
            if (req_i[cand[IW-1:0]]) begin
                grant_o                 = '0;
                grant_o[cand[IW-1:0]]   = 1'b1;
                index_o                 = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/i2c_master_scheduler.sv
// Shares one I2C master among NUM_REQ requesters: round-robin arbitration,
// one-cycle start strobe, per-transaction timeout and result reporting.
//
// state   | meaning
// IDLE    | no owner; wait for any req with master not busy
// ARB     | pick requester, latch its command, assert grant
// ISSUE   | m_enable high for this one cycle, timeout counter cleared
// WAIT    | count cycles until m_done or timeout
// RESP    | done[owner] high, status/rdata valid, grant drops after
module i2c_master_scheduler
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [1:0]             status,
    output logic [7:0]             rdata,
    output logic                   m_enable,
    output logic [6:0]             m_address,
    output logic                   m_rw,
    output logic [7:0]             m_data_in,
    input  logic                   m_busy,
    input  logic                   m_done,
    input  logic                   m_nack,
    input  logic [7:0]             m_rdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] OWNER_INIT = IW'(NUM_REQ - 1);

    state_e               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [IW-1:0]        owner_q;
    logic [IW-1:0]        last_owner_q;
    logic [CW-1:0]        tmo_cnt_q;
    logic [1:0]           status_q;
    logic [7:0]           rdata_q;
    logic                 m_enable_q;
    logic [6:0]           m_address_q;
    logic                 m_rw_q;
    logic [7:0]           m_data_in_q;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IW-1:0]        arb_index;
    logic [6:0]           sel_addr;
    logic                 sel_rw;
    logic [7:0]           sel_wdata;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .grant_o      (arb_grant),
        .index_o      (arb_index)
    );

    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_index == IW'(i)) begin
                sel_addr  = req_addr[7*i +: 7];
                sel_rw    = req_rw[i];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            owner_q      <= '0;
            last_owner_q <= OWNER_INIT;
            tmo_cnt_q    <= '0;
            status_q     <= ST_OK;
            rdata_q      <= '0;
            m_enable_q   <= 1'b0;
            m_address_q  <= '0;
            m_rw_q       <= 1'b0;
            m_data_in_q  <= '0;
        end else begin
            done_q     <= '0;
            m_enable_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req && !m_busy) state_q <= S_ARB;
                end
                S_ARB: begin
                    // A request withdrawn before arbitration simply returns to idle.
                    if (|arb_grant) begin
                        grant_q     <= arb_grant;
                        owner_q     <= arb_index;
                        m_address_q <= sel_addr;
                        m_rw_q      <= sel_rw;
                        m_data_in_q <= sel_wdata;
                        m_enable_q  <= 1'b1;
                        state_q     <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt_q <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (m_done) begin
                        status_q <= m_nack ? ST_NACK : ST_OK;
                        rdata_q  <= m_rdata;
                        done_q   <= grant_q;
                        state_q  <= S_RESP;
                    end else if (tmo_cnt_q == TO_LAST) begin
                        status_q <= ST_TIMEOUT;
                        done_q   <= grant_q;
                        state_q  <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    last_owner_q <= owner_q;
                    grant_q      <= '0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign status    = status_q;
    assign rdata     = rdata_q;
    assign m_enable  = m_enable_q;
    assign m_address = m_address_q;
    assign m_rw      = m_rw_q;
    assign m_data_in = m_data_in_q;

endmodule

// File: tb/tb_i2c_master_scheduler.sv
// Directed bench for i2c_master_scheduler: a vector table of single-requester
// transactions plus hand-written reset, contention, NACK and timeout sequences.
module tb_i2c_master_scheduler;
    import i2c_pkg::*;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req, t_req;
    logic [7*N-1:0]   req_addr;
    logic [N-1:0]     req_rw;
    logic [8*N-1:0]   req_wdata;
    logic             m_busy, m_done, t_m_done, m_nack;
    logic [7:0]       m_rdata;

    logic [N-1:0]     grant, done, t_grant, t_done;
    logic [1:0]       status, t_status;
    logic [7:0]       rdata, t_rdata, m_data_in, t_m_data_in;
    logic             m_enable, m_rw, t_m_enable, t_m_rw;
    logic [6:0]       m_address, t_m_address;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_master_scheduler #(.NUM_REQ(N)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .grant(grant), .done(done), .status(status),
        .rdata(rdata), .m_enable(m_enable), .m_address(m_address), .m_rw(m_rw),
        .m_data_in(m_data_in), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
        .m_rdata(m_rdata)
    );

    // Second instance with a short timeout for the abort corner cases.
    i2c_master_scheduler #(.NUM_REQ(N), .TIMEOUT_CYC(16)) u_dut_to (
        .clk(clk), .rst(rst), .req(t_req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata(req_wdata), .grant(t_grant), .done(t_done), .status(t_status),
        .rdata(t_rdata), .m_enable(t_m_enable), .m_address(t_m_address), .m_rw(t_m_rw),
        .m_data_in(t_m_data_in), .m_busy(m_busy), .m_done(t_m_done), .m_nack(m_nack),
        .m_rdata(m_rdata)
    );

    typedef struct {
        int         idx;
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        int         dly;
        logic       nack;
        logic [7:0] rd_in;
        logic [1:0] exp_st;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (!$onehot0(grant) || !$onehot0(t_grant)) begin
                errors++;
                $display("FAIL grant_onehot actual=%b/%b expected at most one bit", grant, t_grant);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_enable(input string name);
        int n = 0;
        while (!m_enable && n < 8) begin
            tick();
            n++;
        end
        chk(name, m_enable, 1);
    endtask

    task automatic serve(input logic nk, input logic [7:0] rd);
        tick();
        m_done  = 1'b1;
        m_nack  = nk;
        m_rdata = rd;
        tick();
        m_done  = 1'b0;
        m_nack  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] oh;
        oh = 32'd1 << v.idx;
        req_addr[7*v.idx +: 7]  = v.addr;
        req_rw[v.idx]           = v.rw;
        req_wdata[8*v.idx +: 8] = v.wdata;
        req[v.idx]              = 1'b1;
        tick();
        chk("arb_no_enable", m_enable, 0);
        tick();
        chk("issue_enable", m_enable, 1);
        chk("m_address", m_address, v.addr);
        chk("m_rw", m_rw, v.rw);
        chk("m_data_in", m_data_in, v.wdata);
        chk("grant", grant, oh);
        tick();
        chk("enable_one_cycle", m_enable, 0);
        repeat (v.dly) tick();
        m_done  = 1'b1;
        m_nack  = v.nack;
        m_rdata = v.rd_in;
        tick();
        m_done  = 1'b0;
        m_nack  = 1'b0;
        chk("done_pulse", done, oh);
        chk("status", status, v.exp_st);
        if (v.rw) chk("rdata", rdata, v.exp_rd);
        chk("m_address_stable", m_address, v.addr);
        req[v.idx] = 1'b0;
        tick();
        chk("done_cleared", done, 0);
        chk("grant_dropped", grant, 0);
        chk("status_hold", status, v.exp_st);
    endtask

    initial begin
        int n;
        logic [6:0] exp_addr [N];

        vecs[0] = '{1, 7'h50, 1'b0, 8'hA5, 40, 1'b0, 8'h00, ST_OK,   8'h00};
        vecs[1] = '{2, 7'h3A, 1'b1, 8'h00,  5, 1'b0, 8'h3C, ST_OK,   8'h3C};
        vecs[2] = '{0, 7'h7F, 1'b0, 8'h00,  1, 1'b1, 8'h00, ST_NACK, 8'h00};
        vecs[3] = '{3, 7'h01, 1'b1, 8'h11,  0, 1'b0, 8'hC3, ST_OK,   8'hC3};
        vecs[4] = '{2, 7'h22, 1'b0, 8'h5A, 10, 1'b1, 8'h00, ST_NACK, 8'h00};

        rst = 1'b0;  req = '0; t_req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
        m_busy = 1'b0; m_done = 1'b0; t_m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;

        #1;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_enable", m_enable, 0);
        chk("rst_status", status, ST_OK);
        chk("rst_rdata", rdata, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_m_rw", m_rw, 0);
        chk("rst_m_data_in", m_data_in, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("release_grant", grant, 0);
        chk("release_enable", m_enable, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during WAIT: outputs clear asynchronously, no done ever appears.
        req[2] = 1'b1;
        repeat (4) tick();
        chk("midwait_grant_before", grant, 4'b0100);
        #2 rst = 1'b0;
        #1;
        chk("async_grant", grant, 0);
        chk("async_m_address", m_address, 0);
        chk("async_m_data_in", m_data_in, 0);
        chk("async_status", status, ST_OK);
        chk("async_rdata", rdata, 0);
        req = '0;
        repeat (3) begin
            tick();
            chk("no_done_in_reset", done, 0);
        end
        rst = 1'b1;
        req = 4'b1001;
        tick();
        chk("post_rst_no_change", grant, 0);
        wait_enable("post_rst_enable");
        chk("post_rst_first_req0", grant, 4'b0001);
        serve(1'b1, 8'h00);
        chk("nack_done", done, 4'b0001);
        chk("nack_status", status, ST_NACK);
        req[0] = 1'b0;
        tick();
        chk("nack_grant_drop", grant, 0);
        wait_enable("next_enable");
        chk("next_req3", grant, 4'b1000);
        serve(1'b0, 8'h00);
        chk("next_done", done, 4'b1000);
        chk("next_status", status, ST_OK);
        req = '0;
        tick();

        // Contention: all requesters held from reset, served 0,1,2,3,0.
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        req_addr = {7'h01, 7'h22, 7'h50, 7'h7F};
        exp_addr = '{7'h7F, 7'h50, 7'h22, 7'h01};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_enable("rr_enable");
            chk("rr_grant", grant, 32'd1 << (k % N));
            chk("rr_addr", m_address, exp_addr[k % N]);
            serve(1'b0, 8'h00);
            chk("rr_done", done, 32'd1 << (k % N));
            if (k == 4) req = '0;
        end
        tick();

        // Timeout instance (16 cycles): m_done in the 16th WAIT cycle still wins.
        req_rw[1] = 1'b1;
        t_req[1]  = 1'b1;
        n = 0;
        while (!t_m_enable && n < 8) begin tick(); n++; end
        chk("to_enable_a", t_m_enable, 1);
        repeat (16) tick();
        chk("to_no_done_yet", t_done, 0);
        t_m_done = 1'b1;
        m_rdata  = 8'h99;
        tick();
        t_m_done = 1'b0;
        chk("to_edge_done", t_done, 4'b0010);
        chk("to_edge_status", t_status, ST_OK);
        chk("to_edge_rdata", t_rdata, 8'h99);
        t_req = '0;
        tick();

        // No m_done at all: abort decided in WAIT cycle 16, done pulses the cycle after.
        t_req[1] = 1'b1;
        m_rdata  = 8'h00;
        n = 0;
        while (!t_m_enable && n < 8) begin tick(); n++; end
        chk("to_enable_b", t_m_enable, 1);
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (t_done != 0) begin
                n = c;
                break;
            end
        end
        chk("to_done_cycle", n, 17);
        chk("to_done_owner", t_done, 4'b0010);
        chk("to_status", t_status, ST_TIMEOUT);
        chk("to_rdata_hold", t_rdata, 8'h99);
        t_req = '0;
        tick();
        chk("to_grant_drop", t_grant, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
